// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: default widths,
// controller state encoding and the control-bundle layout.
package mul_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_PWIDTH = 2 * DEF_WIDTH;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  typedef struct packed {
    logic lda;
    logic ldb;
    logic ldp;
    logic clrp;
    logic decb;
  } ctrl_t;

endpackage

// File: rtl/mul_down_counter.sv
// B operand register: parallel load, saturating decrement, zero flag and
// an underflow strobe when a decrement is requested at zero.
module mul_down_counter
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero_c,
  output logic             uflow_c
);

  assign zero_c  = (q == '0);
  assign uflow_c = dec && !load && zero_c;

  // Load wins over decrement; decrement sticks at zero instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (dec && !zero_c) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mul_datapath.sv
// Datapath of the repeated-addition multiplier: A operand, B down-counter,
// P accumulator and a sticky underflow flag.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              lda,
  input  logic              ldb,
  input  logic              ldp,
  input  logic              clrp,
  input  logic              decb,
  output logic              eqz,
  output logic [PWIDTH-1:0] product,
  output logic              underflow
);

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PWIDTH-1:0] p_q;
  logic              b_zero_c;
  logic              b_uflow_c;

  mul_down_counter #(.WIDTH(WIDTH)) u_b (
    .clk     (clk),
    .rst     (rst),
    .load    (ldb),
    .dec     (decb),
    .d       (data_in),
    .q       (b_q),
    .zero_c  (b_zero_c),
    .uflow_c (b_uflow_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
    end else if (lda) begin
      a_q <= data_in;
    end
  end

  // Accumulation is gated on B != 0 so the controller's one-cycle lag on
  // eqz cannot add an extra copy of A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      underflow <= 1'b0;
    end else if (clrp) begin
      p_q       <= '0;
      underflow <= 1'b0;
    end else begin
      if (ldp && !b_zero_c) begin
        p_q <= p_q + PWIDTH'(a_q);
      end
      if (b_uflow_c) begin
        underflow <= 1'b1;
      end
    end
  end

  assign eqz     = b_zero_c;
  assign product = p_q;

endmodule

// File: doc/mul_datapath.md
MUL_DATAPATH -- requirements
Module: mul_datapath

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter: PWIDTH, default 2*WIDTH, product width in bits.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: data_in  input  WIDTH  shared operand bus; captured into A or B.
REQ-006 SHALL have port: lda  input  1  load A from data_in.
REQ-007 SHALL have port: ldb  input  1  load B from data_in.
REQ-008 SHALL have port: ldp  input  1  accumulate: P <= P + A.
REQ-009 SHALL have port: clrp  input  1  clear P and underflow flag.
REQ-010 SHALL have port: decb  input  1  decrement B by one.
REQ-011 SHALL have port: eqz  output  1  high when B == 0; combinational from the B register.
REQ-012 SHALL have port: product  output  PWIDTH  current P register value.
REQ-013 SHALL have port: underflow  output  1  sticky; decb was seen while B == 0.

Function
REQ-014 SHALL act as the datapath of the repeated-addition multiplier; the sequencing FSM drives lda/ldb/ldp/clrp/decb and consumes eqz.
REQ-015 SHALL, on lda high at a rising edge, load A <= data_in, regardless of the other controls.
REQ-016 SHALL, on ldb high at a rising edge, load B <= data_in; ldb has priority over decb.
REQ-017 SHALL, with lda and ldb both high, load data_in into both A and B in the same cycle.
REQ-018 SHALL, on decb with ldb low and B != 0, perform B <= B - 1.
REQ-019 SHALL, on decb with ldb low and B == 0, hold B at 0 (no wrap) and set underflow.
REQ-020 SHALL, on ldp with clrp low, perform P <= P + zero-extended A only when B != 0 at that edge; with B == 0, P holds (exact product despite one-cycle controller lag on eqz).
REQ-021 SHALL give clrp priority over ldp: P <= 0 and underflow <= 0.
REQ-022 SHALL make the P addition PWIDTH bits wide with no overflow possible for PWIDTH >= 2*WIDTH; result after B reaches 0 = A_in * B_in.
REQ-023 SHALL make eqz reflect the new B value in the cycle after the edge that updates B (zero cycles of combinational latency from B).
REQ-024 SHALL produce a result that is final in the cycle eqz first goes high following the last ldp/decb pair; a B operand of 0 gives product 0 with no accumulation.
REQ-025 SHALL, with A == 0, leave P at 0 while B still counts down to 0.
REQ-026 SHALL hold all registers when no control is asserted.

Reset
REQ-027 SHALL, on rst high, immediately and asynchronously set A=0, B=0, P=0, underflow=0; eqz consequently high, product 0.
REQ-028 SHALL abandon any multiplication in progress on mid-operation reset; controls are ignored while rst is high, and the first edge after rst deasserts obeys the control inputs.

Structure
REQ-029 SHALL take WIDTH/PWIDTH defaults and the controller state encodings (s0..s4) from shared package mul_pkg, so the controller and datapath agree.
REQ-030 SHALL implement B as sub-module mul_down_counter (load, saturating decrement, zero flag, underflow pulse); A, P and the adder stay in mul_datapath.
REQ-031 SHALL contain no delays in RTL; all registers are edge-triggered flops with async reset.

Verification
REQ-032 SHALL cover: lda with data_in=17, ldb with data_in=5, clrp, then ldp+decb held until eqz -> product=85, underflow=0.
REQ-033 SHALL cover: A=1234, B=0 with ldp+decb for 3 cycles -> product=0, B=0, underflow=1, eqz=1 throughout.
REQ-034 SHALL cover: A=65535, B=65535 run to eqz -> product=4294836225 (0xFFFE0001), no wrap.
REQ-035 SHALL cover: clrp and ldp high together with A=9 -> P=0 next cycle; ldb and decb together with data_in=4 -> B=4.
REQ-036 SHALL cover: rst asserted mid-run (B=3, P=40) between clock edges -> A/B/P/underflow zero before the next edge, eqz=1.
REQ-037 SHALL cover: controller plus datapath end-to-end with start, A=7, B=6 -> done=1 and product=42, with product stable after done.
